// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - default widths and signed data/accumulator types for the processing element
package pe_pkg;

  localparam int unsigned PE_DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned PE_ACC_WIDTH_DEFAULT  = 32;

  typedef logic signed [PE_DATA_WIDTH_DEFAULT-1:0] pe_data_t;
  typedef logic signed [PE_ACC_WIDTH_DEFAULT-1:0]  pe_acc_t;

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - combinational psum + weight*activation; saturating when PE_SATURATE_EN is defined
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = PE_DATA_WIDTH_DEFAULT,
  parameter int unsigned ACCUMULATOR_DATA_WIDTH = PE_ACC_WIDTH_DEFAULT
) (
  input  logic signed [DATA_WIDTH-1:0]             weight_i,
  input  logic signed [DATA_WIDTH-1:0]             act_i,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] psum_i,
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] psum_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned AW = ACCUMULATOR_DATA_WIDTH;

  logic signed [PW-1:0] product;
  logic signed [AW-1:0] product_ext;

  assign product     = weight_i * act_i;
  assign product_ext = AW'(product);

`ifdef PE_SATURATE_EN
  // One guard bit exposes overflow: the top two bits of the wide sum disagree.
  logic signed [AW:0] sum_wide;

  assign sum_wide = (AW + 1)'(psum_i) + (AW + 1)'(product_ext);

  always_comb begin
    psum_o = sum_wide[AW-1:0];
    if (sum_wide[AW] != sum_wide[AW-1]) begin
      psum_o = sum_wide[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
    end
  end
`else
  assign psum_o = psum_i + product_ext;
`endif

endmodule

// File: rtl/processing_element.sv
// rtl/processing_element.sv - weight-stationary systolic PE; PE_SATURATE_EN selects saturating accumulate
module processing_element
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = PE_DATA_WIDTH_DEFAULT,
  parameter int unsigned ACCUMULATOR_DATA_WIDTH = PE_ACC_WIDTH_DEFAULT
) (
  input  logic                                     CLK,
  input  logic                                     SYNC_RST,
  input  logic                                     EN,
  input  logic                                     LOAD,
  input  logic signed [DATA_WIDTH-1:0]             Input,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
  output logic signed [DATA_WIDTH-1:0]             ToRight,
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumOut
);

  logic signed [DATA_WIDTH-1:0]             weight_q, weight_d;
  logic signed [DATA_WIDTH-1:0]             to_right_q, to_right_d;
  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] psum_q, psum_d;
  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] mac_result;

  pe_mac #(
    .DATA_WIDTH             (DATA_WIDTH),
    .ACCUMULATOR_DATA_WIDTH (ACCUMULATOR_DATA_WIDTH)
  ) u_mac (
    .weight_i (weight_q),
    .act_i    (Input),
    .psum_i   (PsumIn),
    .psum_o   (mac_result)
  );

  // LOAD takes priority over EN: a weight update cycle never computes or forwards.
  always_comb begin
    weight_d   = weight_q;
    to_right_d = to_right_q;
    psum_d     = psum_q;
    if (LOAD) begin
      weight_d = Input;
    end else if (EN) begin
      to_right_d = Input;
      psum_d     = mac_result;
    end
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      weight_q   <= '0;
      to_right_q <= '0;
      psum_q     <= '0;
    end else begin
      weight_q   <= weight_d;
      to_right_q <= to_right_d;
      psum_q     <= psum_d;
    end
  end

  assign ToRight = to_right_q;
  assign PsumOut = psum_q;

endmodule

// File: tb/tb_processing_element.sv
// tb/tb_processing_element.sv - directed self-checking bench for processing_element
module tb_processing_element;

  logic               CLK;
  logic               SYNC_RST;
  logic               EN;
  logic               LOAD;
  logic signed [7:0]  Input;
  logic signed [31:0] PsumIn;
  logic signed [7:0]  ToRight;
  logic signed [31:0] PsumOut;

  int n_checks;
  int n_fails;

  processing_element #(
    .DATA_WIDTH             (8),
    .ACCUMULATOR_DATA_WIDTH (32)
  ) dut (
    .CLK      (CLK),
    .SYNC_RST (SYNC_RST),
    .EN       (EN),
    .LOAD     (LOAD),
    .Input    (Input),
    .PsumIn   (PsumIn),
    .ToRight  (ToRight),
    .PsumOut  (PsumOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic rst, input logic load, input logic en,
                       input logic signed [7:0] in_v, input logic signed [31:0] ps_v);
    SYNC_RST = rst;
    LOAD     = load;
    EN       = en;
    Input    = in_v;
    PsumIn   = ps_v;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b1, 8'sd9, 32'sd0);
    tick();
    n_checks++;
    if (ToRight !== 8'sd0) begin
      n_fails++;
      $display("FAIL reset_to_right: got %0d expected 0", ToRight);
    end
    n_checks++;
    if (PsumOut !== 32'sd0) begin
      n_fails++;
      $display("FAIL reset_psum: got %0d expected 0", PsumOut);
    end
    // Weight must be zero after reset: MAC returns PsumIn unchanged.
    drive(1'b0, 1'b0, 1'b1, 8'sd4, 32'sd1);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd1) begin
      n_fails++;
      $display("FAIL reset_weight_zero: got %0d expected 1", PsumOut);
    end
  endtask

  task automatic test_basic_mac;
    drive(1'b0, 1'b1, 1'b0, 8'sd50, 32'sd0);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd1 || ToRight !== 8'sd4) begin
      n_fails++;
      $display("FAIL load_holds_outputs: got psum=%0d tr=%0d expected psum=1 tr=4", PsumOut, ToRight);
    end
    drive(1'b0, 1'b0, 1'b1, 8'sd4, 32'sd1);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd201) begin
      n_fails++;
      $display("FAIL mac_basic_psum: got %0d expected 201", PsumOut);
    end
    n_checks++;
    if (ToRight !== 8'sd4) begin
      n_fails++;
      $display("FAIL mac_basic_to_right: got %0d expected 4", ToRight);
    end
    tick();
    n_checks++;
    if (PsumOut !== 32'sd201) begin
      n_fails++;
      $display("FAIL mac_repeat_psum: got %0d expected 201", PsumOut);
    end
  endtask

  task automatic test_signed;
    drive(1'b0, 1'b1, 1'b0, -8'sd128, 32'sd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, -8'sd128, 32'sd0);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd16384) begin
      n_fails++;
      $display("FAIL signed_min_sq: got %0d expected 16384", PsumOut);
    end
    n_checks++;
    if (ToRight !== -8'sd128) begin
      n_fails++;
      $display("FAIL signed_to_right: got %0d expected -128", ToRight);
    end
    drive(1'b0, 1'b1, 1'b0, -8'sd3, 32'sd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'sd5, 32'sd10);
    tick();
    n_checks++;
    if (PsumOut !== -32'sd5) begin
      n_fails++;
      $display("FAIL signed_neg_result: got %0d expected -5", PsumOut);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_ovf;
    logic [31:0] exp_unf;
`ifdef PE_SATURATE_EN
    exp_ovf = 32'h7FFF_FFFF;
    exp_unf = 32'h8000_0000;
`else
    exp_ovf = 32'h8000_3F00;
    exp_unf = 32'h7FFF_C080;
`endif
    drive(1'b0, 1'b1, 1'b0, 8'sd127, 32'sd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'sd127, 32'sh7FFF_FFFF);
    tick();
    n_checks++;
    if (PsumOut !== exp_ovf) begin
      n_fails++;
      $display("FAIL overflow: got %08h expected %08h", PsumOut, exp_ovf);
    end
    drive(1'b0, 1'b1, 1'b0, -8'sd128, 32'sd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'sd127, 32'sh8000_0000);
    tick();
    n_checks++;
    if (PsumOut !== exp_unf) begin
      n_fails++;
      $display("FAIL underflow: got %08h expected %08h", PsumOut, exp_unf);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b1, 1'b0, 8'sd2, 32'sd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'sd3, 32'sd4);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd10 || ToRight !== 8'sd3) begin
      n_fails++;
      $display("FAIL hold_setup: got psum=%0d tr=%0d expected psum=10 tr=3", PsumOut, ToRight);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'(i * 17 - 40), 32'(i * 1000 + 7));
      tick();
      n_checks++;
      if (PsumOut !== 32'sd10 || ToRight !== 8'sd3) begin
        n_fails++;
        $display("FAIL en_low_hold[%0d]: got psum=%0d tr=%0d expected psum=10 tr=3", i, PsumOut, ToRight);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 8'sd7, 32'sd99);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd10 || ToRight !== 8'sd3) begin
      n_fails++;
      $display("FAIL load_priority_hold: got psum=%0d tr=%0d expected psum=10 tr=3", PsumOut, ToRight);
    end
    drive(1'b0, 1'b0, 1'b1, 8'sd2, 32'sd1);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd15 || ToRight !== 8'sd2) begin
      n_fails++;
      $display("FAIL load_priority_weight: got psum=%0d tr=%0d expected psum=15 tr=2", PsumOut, ToRight);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 1'b0, 8'sd5, 32'sd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'sd4, 32'sd1);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd21) begin
      n_fails++;
      $display("FAIL mid_first_mac: got %0d expected 21", PsumOut);
    end
    drive(1'b1, 1'b0, 1'b1, 8'sd4, 32'sd1);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd0 || ToRight !== 8'sd0) begin
      n_fails++;
      $display("FAIL mid_reset: got psum=%0d tr=%0d expected 0 0", PsumOut, ToRight);
    end
    drive(1'b0, 1'b0, 1'b1, 8'sd4, 32'sd1);
    tick();
    n_checks++;
    if (PsumOut !== 32'sd1 || ToRight !== 8'sd4) begin
      n_fails++;
      $display("FAIL mid_no_reload: got psum=%0d tr=%0d expected psum=1 tr=4", PsumOut, ToRight);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    drive(1'b1, 1'b0, 1'b0, 8'sd0, 32'sd0);
    @(negedge CLK);
    test_reset();
    test_basic_mac();
    test_signed();
    test_overflow();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
